// File: rtl/adder_share_arb_pkg.sv
// Shared types and defaults for the shared-adder arbiter: FSM encoding and
// default requester count / operand width.
package adder_share_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder_share_arb_if.sv
// Request/response bus of the shared-adder arbiter. The master drives requests
// and consumes results; the slave (the arbiter) grants and returns sums.
interface adder_share_arb_if #(
    parameter int N_REQ = adder_share_arb_pkg::N_REQ_DEF,
    parameter int WIDTH = adder_share_arb_pkg::WIDTH_DEF
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_cin;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH:0]         rsp_sum;
    logic [15:0]            op_count;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, op_count
    );

endinterface

// File: rtl/adder_share_arb_bk_adder.sv
// Brent-Kung parallel-prefix adder core (32-bit by default): sum = a + b + cin
// with the carry-out as the extra MSB.
module bk_prefix_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH:0]   sum_o
);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;

    always_comb begin
        p  = a_i ^ b_i;
        pp = p;
        gg = a_i & b_i;
        // Folding cin into bit 0 makes every prefix generate a true carry.
        gg[0] = gg[0] | (p[0] & cin_i);

        // Up-sweep: build group generate/propagate on a binary tree.
        for (int d = 1; d < WIDTH; d = d * 2) begin
            for (int i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end

        // Down-sweep: fill in the prefixes the tree skipped.
        for (int d = WIDTH / 2; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
            end
        end

        sum_o[0] = p[0] ^ cin_i;
        for (int i = 1; i < WIDTH; i++) begin
            sum_o[i] = p[i] ^ gg[i-1];
        end
        sum_o[WIDTH] = gg[WIDTH-1];
    end

endmodule

// File: rtl/adder_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// grant and the first asserted request wins. No grant while en_i is low.
module rr_arbiter
    import adder_share_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_grant_i,
    input  logic                     en_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] gnt_idx_o
);
    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        // N_REQ is a power of two, so the index wraps by plain truncation.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last_grant_i + ID_W'(k);
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// N requesters share one prefix adder: round-robin accept, one cycle to add,
// then the result is held until the consumer takes it.
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arb_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    state_e          state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic            op_cin_q, op_cin_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    logic [WIDTH:0]  rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]     op_count_q, op_count_d;

    logic             accept_en;
    logic             accept;
    logic             rsp_fire;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic [WIDTH:0]   add_sum;

    // Reset also gates the grant so req_ready is quiet while rst_n is low.
    assign accept_en = rst_n &&
                       ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
    assign accept    = |gnt;
    assign rsp_fire  = (state_q == RESP) && bus.rsp_ready;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .en_i         (accept_en),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx)
    );

    bk_prefix_adder #(.WIDTH(WIDTH)) u_add (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .cin_i (op_cin_q),
        .sum_o (add_sum)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_cin_d     = op_cin_q;
        op_id_d      = op_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;
        op_count_d   = op_count_q + {15'd0, rsp_fire};

        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: begin
                state_d   = RESP;
                rsp_sum_d = add_sum;
                rsp_id_d  = op_id_q;
            end
            RESP: if (bus.rsp_ready) state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            last_grant_d = gnt_idx;
            op_a_d       = bus.req_a[int'(gnt_idx) * WIDTH +: WIDTH];
            op_b_d       = bus.req_b[int'(gnt_idx) * WIDTH +: WIDTH];
            op_cin_d     = bus.req_cin[gnt_idx];
            op_id_d      = gnt_idx;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_cin_q     <= 1'b0;
            op_id_q      <= '0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_cin_q     <= op_cin_d;
            op_id_q      <= op_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_id_q     <= rsp_id_d;
            op_count_q   <= op_count_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.op_count  = op_count_q;

endmodule
